// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core run/halt/step controller.
package core_ctrl_pkg;

   // Host command opcodes as carried on cmd_op.
   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_RUN     = 3'd1,
      OP_HALT    = 3'd2,
      OP_STEP    = 3'd3,
      OP_SET_BP  = 3'd4,
      OP_CLR_BP  = 3'd5,
      OP_CLR_CNT = 3'd6,
      OP_INVALID = 3'd7
   } cmd_op_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_HALTED = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2
   } ctrl_state_e;

   // Reason for the most recent entry into HALTED.
   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_RSVD   = 2'd1,
      CAUSE_BP     = 2'd2,
      CAUSE_EBREAK = 2'd3
   } halt_cause_e;

   // RV32I EBREAK encoding.
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, otherwise add the increment and wrap naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle RV32I core. Gates core
// progress through core_en, stops on host HALT, PC breakpoint or EBREAK, and
// keeps cycle and retired-instruction counters.
module core_run_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [XLEN-1:0]  cmd_data,
   input  logic [XLEN-1:0]  pc_number,
   input  logic [31:0]      inst,
   output logic             core_en,
   output logic             running,
   output logic             halted_pulse,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   ctrl_state_e      state_q, state_d;
   halt_cause_e      cause_q, cause_d;
   logic             skip_bp_q, skip_bp_d;
   logic             bp_en_q, bp_en_d;
   logic [XLEN-1:0]  bp_addr_q, bp_addr_d;
   logic             halted_pulse_q;

   cmd_op_e          op;
   logic             cmd_acc;
   logic             ebreak_hit;
   logic             bp_hit;
   logic             host_halt;
   logic             clr_cnt;
   logic             enter_halt;

   assign op         = cmd_op_e'(cmd_op);
   // Ready is held low while reset is asserted even though the reset state is HALTED.
   assign cmd_ready  = rst_n && (state_q != ST_STEP);
   assign cmd_acc    = cmd_valid && cmd_ready;
   assign ebreak_hit = (inst == EBREAK_INST);
   assign bp_hit     = bp_en_q && (pc_number == bp_addr_q) && !skip_bp_q;
   assign host_halt  = cmd_acc && (op == OP_HALT);
   assign clr_cnt    = cmd_acc && (op == OP_CLR_CNT);

   // Next-state, core enable and configuration updates.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d    = state_q;
      cause_d    = cause_q;
      skip_bp_d  = skip_bp_q;
      bp_en_d    = bp_en_q;
      bp_addr_d  = bp_addr_q;
      core_en    = 1'b0;
      enter_halt = 1'b0;

      if (cmd_acc && op == OP_SET_BP) begin
         bp_en_d   = 1'b1;
         bp_addr_d = cmd_data;
      end else if (cmd_acc && op == OP_CLR_BP) begin
         bp_en_d   = 1'b0;
      end

      case (state_q)
         ST_HALTED: begin
            if (cmd_acc && (op == OP_RUN || op == OP_STEP)) begin
               state_d   = (op == OP_RUN) ? ST_RUN : ST_STEP;
               skip_bp_d = 1'b1;
               cause_d   = CAUSE_NONE;
            end
         end
         ST_STEP: begin
            // The host asked for this instruction explicitly: no EBREAK/breakpoint check.
            core_en    = 1'b1;
            state_d    = ST_HALTED;
            cause_d    = CAUSE_NONE;
            enter_halt = 1'b1;
         end
         ST_RUN: begin
            if (ebreak_hit || bp_hit || host_halt) begin
               // The stopping instruction is not executed; the PC stays on it.
               state_d    = ST_HALTED;
               enter_halt = 1'b1;
               if (ebreak_hit) begin
                  cause_d = CAUSE_EBREAK;
               end else if (bp_hit) begin
                  cause_d = CAUSE_BP;
               end else begin
                  cause_d = CAUSE_NONE;
               end
            end else begin
               core_en = 1'b1;
            end
         end
         default: begin
            state_d = ST_HALTED;
            cause_d = CAUSE_NONE;
         end
      endcase

      // The resumed-from breakpoint is only skipped until one instruction has executed.
      if (core_en) begin
         skip_bp_d = 1'b0;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HALTED;
         cause_q        <= CAUSE_NONE;
         skip_bp_q      <= 1'b0;
         bp_en_q        <= 1'b0;
         bp_addr_q      <= '0;
         halted_pulse_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q        <= state_d;
         cause_q        <= cause_d;
         skip_bp_q      <= skip_bp_d;
         bp_en_q        <= bp_en_d;
         bp_addr_q      <= bp_addr_d;
         halted_pulse_q <= enter_halt;
      end
   end

   assign running      = (state_q == ST_RUN);
   assign halted_pulse = halted_pulse_q;
   assign halt_cause   = cause_q;

   perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (1'b1),
      .clr_i (clr_cnt),
      .cnt_o (cycle_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (core_en),
      .clr_i (clr_cnt),
      .cnt_o (instret_cnt)
   );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl. Expected halt events are queued by the
// stimulus thread and checked by a monitor whenever halted_pulse fires.
module tb_core_run_ctrl;

   localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3,
                          OP_SET_BP = 3'd4, OP_CLR_BP = 3'd5, OP_CLR_CNT = 3'd6, OP_BAD = 3'd7;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP_I  = 32'h0000_0013;

   typedef struct {
      logic [1:0]  cause;
      logic [31:0] instret;
      logic [31:0] pc;
   } halt_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = OP_NOP;
   logic [31:0] cmd_data = '0;
   logic [31:0] pc = '0;
   logic [31:0] inst;
   logic        core_en, running, halted_pulse;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_cnt, instret_cnt;

   logic [31:0] ebk_addr = '0;
   logic        ebk_on = 1'b0;
   int          en_cnt = 0;

   // Narrow-counter instance used for the wrap/clear boundary.
   logic        rst2_n = 1'b0;
   logic        cmd_valid2 = 1'b0;
   logic        cmd_ready2;
   logic [2:0]  cmd_op2 = OP_NOP;
   logic        core_en2, running2, halted_pulse2;
   logic [1:0]  halt_cause2;
   logic [3:0]  cycle_cnt2, instret_cnt2;

   int n_vec = 0;
   int n_err = 0;
   halt_exp_t exp_q[$];

   assign inst = (ebk_on && pc == ebk_addr) ? EBREAK : NOP_I;

   core_run_ctrl #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .pc_number(pc), .inst(inst),
      .core_en(core_en), .running(running), .halted_pulse(halted_pulse),
      .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   core_run_ctrl #(.XLEN(32), .CNT_W(4)) dut_w4 (
      .clk(clk), .rst_n(rst2_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_op(cmd_op2), .cmd_data(32'h0), .pc_number(32'h0), .inst(NOP_I),
      .core_en(core_en2), .running(running2), .halted_pulse(halted_pulse2),
      .halt_cause(halt_cause2), .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [31:0] data);
      int waits = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (!cmd_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!cmd_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL cmd_accept_timeout: op %0d never accepted", op);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_data  = '0;
   endtask

   task automatic expect_halt(input logic [1:0] c, input logic [31:0] n, input logic [31:0] p);
      halt_exp_t e;
      e.cause = c;
      e.instret = n;
      e.pc = p;
      exp_q.push_back(e);
   endtask

   // Core model: the PC advances by 4 after every cycle the controller enables.
   initial begin
      logic en_s;
      forever begin
         @(negedge clk);
         #2;
         en_s = core_en;
         @(posedge clk);
         #1;
         if (en_s) begin
            pc = pc + 32'd4;
            en_cnt++;
         end
      end
   end

   // Monitor: each halted_pulse must match the oldest expected halt.
   initial begin
      halt_exp_t e;
      forever begin
         @(negedge clk);
         if (halted_pulse) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_halt: pc 0x%08h cause %0d at %0t", pc, halt_cause, $time);
            end else begin
               e = exp_q.pop_front();
               check("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
               check("halt_instret", instret_cnt, e.instret);
               check("halt_pc", pc, e.pc);
               check("halt_running", {31'd0, running}, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      // 1: reset and idle counting.
      #1;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_core_en", {31'd0, core_en}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("idle_cycle_cnt", cycle_cnt, 32'd10);
      check("idle_instret", instret_cnt, 32'd0);
      check("idle_core_en", {31'd0, core_en}, 32'd0);
      check("idle_running", {31'd0, running}, 32'd0);
      check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("idle_cause", {30'd0, halt_cause}, 32'd0);

      // 2: three single steps from pc 0.
      for (int k = 1; k <= 3; k++) begin
         expect_halt(2'd0, 32'(k), 32'(4 * k));
         send_cmd(OP_STEP, '0);
         repeat (3) @(posedge clk);
      end
      #1;
      check("step_instret", instret_cnt, 32'd3);
      check("step_en_pulses", 32'(en_cnt), 32'd3);

      // 3: breakpoint at 0x10, run from 0.
      send_cmd(OP_CLR_CNT, '0);
      check("clr_halted_instret", instret_cnt, 32'd0);
      pc = 32'h0;
      send_cmd(OP_SET_BP, 32'h10);
      expect_halt(2'd2, 32'd4, 32'h10);
      send_cmd(OP_RUN, '0);
      check("run_running", {31'd0, running}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      check("bp_core_en", {31'd0, core_en}, 32'd0);
      check("bp_cause_held", {30'd0, halt_cause}, 32'd2);

      // 4: resume over the breakpoint, clear counters mid-run, then host halt.
      expect_halt(2'd0, 32'd2, 32'h24);
      send_cmd(OP_RUN, '0);
      repeat (2) @(posedge clk);
      send_cmd(OP_CLR_CNT, '0);
      check("clr_run_instret", instret_cnt, 32'd0);
      check("clr_run_cycle", cycle_cnt, 32'd0);
      repeat (2) @(posedge clk);
      send_cmd(OP_HALT, '0);
      repeat (3) @(posedge clk);

      // 5a: EBREAK at 0x8, then RUN again on it halts immediately.
      send_cmd(OP_CLR_BP, '0);
      send_cmd(OP_CLR_CNT, '0);
      pc = 32'h0;
      ebk_addr = 32'h8;
      ebk_on = 1'b1;
      expect_halt(2'd3, 32'd2, 32'h8);
      send_cmd(OP_RUN, '0);
      repeat (6) @(posedge clk);
      expect_halt(2'd3, 32'd2, 32'h8);
      send_cmd(OP_RUN, '0);
      repeat (4) @(posedge clk);

      // 5b: EBREAK and breakpoint on the same pc: EBREAK wins.
      send_cmd(OP_CLR_CNT, '0);
      pc = 32'h0;
      send_cmd(OP_SET_BP, 32'h8);
      expect_halt(2'd3, 32'd2, 32'h8);
      send_cmd(OP_RUN, '0);
      repeat (6) @(posedge clk);
      ebk_on = 1'b0;

      // Invalid opcode is accepted and changes nothing.
      send_cmd(OP_BAD, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      #1;
      check("bad_op_running", {31'd0, running}, 32'd0);
      check("bad_op_cause", {30'd0, halt_cause}, 32'd3);
      check("bad_op_instret", instret_cnt, 32'd2);

      // 6a: asynchronous reset in the middle of a run.
      pc = 32'h100;
      send_cmd(OP_RUN, '0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_core_en", {31'd0, core_en}, 32'd0);
      check("arst_running", {31'd0, running}, 32'd0);
      check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("arst_cycle", cycle_cnt, 32'd0);
      check("arst_instret", instret_cnt, 32'd0);
      check("arst_pulse", {31'd0, halted_pulse}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_cycle", cycle_cnt, 32'd3);
      check("post_rst_running", {31'd0, running}, 32'd0);

      // 6b: narrow counters at all-ones with core_en=1, then CLR_CNT.
      @(negedge clk);
      rst2_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("w4_cycle_max", {28'd0, cycle_cnt2}, 32'd15);
      @(negedge clk);
      cmd_valid2 = 1'b1;
      cmd_op2 = OP_RUN;
      @(posedge clk);
      #1;
      cmd_valid2 = 1'b0;
      cmd_op2 = OP_NOP;
      check("w4_cycle_wrap", {28'd0, cycle_cnt2}, 32'd0);
      repeat (15) @(posedge clk);
      #1;
      check("w4_cycle_pre", {28'd0, cycle_cnt2}, 32'd15);
      check("w4_instret_pre", {28'd0, instret_cnt2}, 32'd15);
      check("w4_core_en", {31'd0, core_en2}, 32'd1);
      @(negedge clk);
      cmd_valid2 = 1'b1;
      cmd_op2 = OP_CLR_CNT;
      @(posedge clk);
      #1;
      cmd_valid2 = 1'b0;
      cmd_op2 = OP_NOP;
      check("w4_cycle_clr", {28'd0, cycle_cnt2}, 32'd0);
      check("w4_instret_clr", {28'd0, instret_cnt2}, 32'd0);
      @(posedge clk);
      #1;
      check("w4_cycle_after", {28'd0, cycle_cnt2}, 32'd1);
      check("w4_instret_after", {28'd0, instret_cnt2}, 32'd1);

      // Drain the scoreboard.
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL pending_halts: %0d expected halts never seen, 0 required", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
